exec_unit_pipe: RTL and testbench
=================================

Name: exec_unit_pipe

Overview:
- Parametrised, pipelined integer execution unit for the out-of-order core.
- Accepts one operation per cycle from the reservation station through a valid/ready handshake.
- Computes the full RV32I integer/branch/jump result set and delivers tagged results toward the CDB after STAGES cycles.
- Supports back-pressure from the CDB arbiter and a misprediction flush that squashes all in-flight work.

Parameters:
DATA_W, 32, operand/result width; power of two, at least 8
TAG_W, 4, ROB tag width
OP_W, 6, internal opcode width; opcode values are the team's inside-opcode constants, NOP = 0
STAGES, 2, result latency in cycles, legal 1..4

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; 0 freezes all state
in_valid  in  1  issue request
in_ready  out  1  unit can accept this cycle
in_op  in  OP_W  operation
in_value1  in  DATA_W  rs1 operand
in_value2  in  DATA_W  rs2 operand
in_imm  in  DATA_W  sign-extended immediate
in_pc  in  DATA_W  instruction PC
in_rob_tag  in  TAG_W  destination ROB tag
in_flush  in  1  squash all in-flight ops
out_valid  out  1  result valid
out_ready  in  1  CDB accepts result
out_rob_tag  out  TAG_W  result tag
out_value  out  DATA_W  result, or branch-taken flag (1/0)
out_newpc  out  DATA_W  branch/JALR target
out_is_branch  out  1  result is from a conditional branch
occupancy  out  3  number of valid pipeline slots (0..STAGES)

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits 0, occupancy 0, out_valid 0, all out_* data 0. in_ready is 1 after reset once rdy=1.
- Pipeline: STAGES register slots s1..sSTAGES. The result is computed combinationally from inputs and captured into s1, then shifted; out_* are driven from sSTAGES.
- advance = rdy & (out_ready | ~out_valid). in_ready = advance & ~in_flush.
- The issue handshake completes when in_valid & in_ready; the op appears on out_valid exactly STAGES cycles later if no stall occurs.
- When advance=0, every slot holds its value and the output stays stable while out_valid=1 and out_ready=0.
- Bubbles are not collapsed: a global stall freezes the whole pipeline.
- in_op = NOP with in_valid=1 is accepted and produces no slot. The s1 valid bit is 0 for that op.
- in_flush=1 (rdy=1): every valid bit clears at the next edge; the same-cycle issue is dropped; out_valid=0 next cycle. A flush overrides a stall.
- While rdy=0, in_flush is ignored.
- out_* data fields read 0 whenever out_valid=0.
- Arithmetic is modulo 2^DATA_W. Shift amount is operand[log2(DATA_W)-1:0].
- LUI: imm.
- AUIPC: pc+imm.
- JAL: value=pc+4.
- JALR: value=pc+4; newpc=(v1+imm) with bit 0 cleared.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: value=1 if taken else 0; newpc=pc+imm; out_is_branch=1. Signed variants use two's-complement compare.
- ADD/SUB use v1 and v2. ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI use v1 and imm.
- SLL/SRL/SRA/SLT/SLTU/XOR/OR/AND use v1 and v2.
- SRA and SRAI are arithmetic (sign-filling).
- For non-branch, non-JALR ops, newpc=0.
- Unknown opcode: accepted; value=0, newpc=0.
- occupancy = count of valid slots, updated each edge.
- Reset asserted mid-operation clears everything immediately; no result escapes.

Test Plan:
- STAGES=2: issue ADD v1=5, v2=7, tag 3 at cycle 0 -> out_valid at cycle 2 with tag 3, value 12, newpc 0, out_is_branch 0.
- Back-to-back SUB 3-5 (tag1), SRA v1=0x80000000 v2=33 (tag2), SLTU 1<0xFFFFFFFF (tag3) -> results 0xFFFFFFFE, 0xC0000000, 1 on consecutive cycles.
- BLT v1=-1, v2=1, pc=0x100, imm=-8 -> value 1, newpc 0xF8, out_is_branch 1. BGEU with the same operands -> value 1. JALR v1=0x203, imm=0, pc=0x40 -> value 0x44, newpc 0x202.
- Issue 3 ops with out_ready=0 -> in_ready drops once s2 is valid; output held stable; occupancy 2. Raise out_ready -> results drain in order with none lost or duplicated.
- With occupancy 2, assert in_flush together with in_valid -> next cycle occupancy 0, out_valid 0, and the flushed ops never appear.
- Assert rst asynchronously mid-stream -> out_valid and occupancy go 0 without a clock edge. With rdy=0, all state is frozen for 5 cycles, then resumes correctly.

Source files
------------

// File: rtl/exec_unit_pipe.sv
// exec_unit_pipe: pipelined RV32I integer/branch/jump execution unit.
//
// One op per cycle is accepted from the reservation station (in_valid/in_ready)
// and its tagged result is presented toward the CDB STAGES cycles later
// (out_valid/out_ready). A global stall freezes the whole pipe without
// collapsing bubbles. in_flush squashes everything in flight.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rdy             global enable; 0 freezes all state (and ignores in_flush)
//   in_valid/ready  issue handshake
//   in_op           internal opcode (exec_unit_pipe_pkg::OP_*)
//   in_value1/2     rs1 / rs2 operands
//   in_imm, in_pc   sign-extended immediate, instruction PC
//   in_rob_tag      destination ROB tag
//   in_flush        squash all in-flight ops
//   out_valid/ready result handshake
//   out_rob_tag     result tag
//   out_value       result, or branch-taken flag for conditional branches
//   out_newpc       branch / JALR target
//   out_is_branch   result comes from a conditional branch
//   occupancy       number of valid pipeline slots

package exec_unit_pipe_pkg;
    localparam int unsigned OP_NOP   = 0;
    localparam int unsigned OP_LUI   = 1;
    localparam int unsigned OP_AUIPC = 2;
    localparam int unsigned OP_JAL   = 3;
    localparam int unsigned OP_JALR  = 4;
    localparam int unsigned OP_BEQ   = 5;
    localparam int unsigned OP_BNE   = 6;
    localparam int unsigned OP_BLT   = 7;
    localparam int unsigned OP_BGE   = 8;
    localparam int unsigned OP_BLTU  = 9;
    localparam int unsigned OP_BGEU  = 10;
    localparam int unsigned OP_ADD   = 11;
    localparam int unsigned OP_SUB   = 12;
    localparam int unsigned OP_SLL   = 13;
    localparam int unsigned OP_SLT   = 14;
    localparam int unsigned OP_SLTU  = 15;
    localparam int unsigned OP_XOR   = 16;
    localparam int unsigned OP_SRL   = 17;
    localparam int unsigned OP_SRA   = 18;
    localparam int unsigned OP_OR    = 19;
    localparam int unsigned OP_AND   = 20;
    localparam int unsigned OP_ADDI  = 21;
    localparam int unsigned OP_SLTI  = 22;
    localparam int unsigned OP_SLTIU = 23;
    localparam int unsigned OP_XORI  = 24;
    localparam int unsigned OP_ORI   = 25;
    localparam int unsigned OP_ANDI  = 26;
    localparam int unsigned OP_SLLI  = 27;
    localparam int unsigned OP_SRLI  = 28;
    localparam int unsigned OP_SRAI  = 29;
endpackage

module exec_unit_pipe
    import exec_unit_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned OP_W   = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_value1,
    input  logic [DATA_W-1:0] in_value2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_rob_tag,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_rob_tag,
    output logic [DATA_W-1:0] out_value,
    output logic [DATA_W-1:0] out_newpc,
    output logic              out_is_branch,
    output logic [2:0]        occupancy
);

    localparam int unsigned SH_W = $clog2(DATA_W);
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] br_q;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [DATA_W-1:0] val_q [STAGES];
    logic [DATA_W-1:0] npc_q [STAGES];

    logic advance;
    logic accept;

    assign out_valid = vld_q[LAST];
    assign advance   = rdy & (out_ready | ~out_valid);
    assign in_ready  = advance & ~in_flush;
    // NOPs complete the handshake but never occupy a slot.
    assign accept    = in_valid & in_ready & (in_op != OP_W'(OP_NOP));

    // ---------------- combinational result ----------------
    logic [DATA_W-1:0] res_val;
    logic [DATA_W-1:0] res_npc;
    logic              res_br;
    logic              taken;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] jalr_sum;
    logic [SH_W-1:0]   sh_r;
    logic [SH_W-1:0]   sh_i;

    assign pc4      = in_pc + DATA_W'(4);
    assign jalr_sum = in_value1 + in_imm;
    assign sh_r     = in_value2[SH_W-1:0];
    assign sh_i     = in_imm[SH_W-1:0];

    always_comb begin
        res_val = '0;
        res_npc = '0;
        res_br  = 1'b0;
        taken   = 1'b0;
        case (in_op)
            OP_W'(OP_LUI):   res_val = in_imm;
            OP_W'(OP_AUIPC): res_val = in_pc + in_imm;
            OP_W'(OP_JAL):   res_val = pc4;
            OP_W'(OP_JALR): begin
                res_val = pc4;
                res_npc = jalr_sum & ~DATA_W'(1);
            end
            OP_W'(OP_BEQ):  begin res_br = 1'b1; taken = (in_value1 == in_value2); end
            OP_W'(OP_BNE):  begin res_br = 1'b1; taken = (in_value1 != in_value2); end
            OP_W'(OP_BLT):  begin res_br = 1'b1; taken = ($signed(in_value1) <  $signed(in_value2)); end
            OP_W'(OP_BGE):  begin res_br = 1'b1; taken = ($signed(in_value1) >= $signed(in_value2)); end
            OP_W'(OP_BLTU): begin res_br = 1'b1; taken = (in_value1 <  in_value2); end
            OP_W'(OP_BGEU): begin res_br = 1'b1; taken = (in_value1 >= in_value2); end
            OP_W'(OP_ADD):   res_val = in_value1 + in_value2;
            OP_W'(OP_SUB):   res_val = in_value1 - in_value2;
            OP_W'(OP_SLL):   res_val = in_value1 << sh_r;
            OP_W'(OP_SRL):   res_val = in_value1 >> sh_r;
            OP_W'(OP_SRA):   res_val = DATA_W'($signed(in_value1) >>> sh_r);
            OP_W'(OP_SLT):   res_val = {{(DATA_W-1){1'b0}}, $signed(in_value1) < $signed(in_value2)};
            OP_W'(OP_SLTU):  res_val = {{(DATA_W-1){1'b0}}, in_value1 < in_value2};
            OP_W'(OP_XOR):   res_val = in_value1 ^ in_value2;
            OP_W'(OP_OR):    res_val = in_value1 | in_value2;
            OP_W'(OP_AND):   res_val = in_value1 & in_value2;
            OP_W'(OP_ADDI):  res_val = in_value1 + in_imm;
            OP_W'(OP_SLTI):  res_val = {{(DATA_W-1){1'b0}}, $signed(in_value1) < $signed(in_imm)};
            OP_W'(OP_SLTIU): res_val = {{(DATA_W-1){1'b0}}, in_value1 < in_imm};
            OP_W'(OP_XORI):  res_val = in_value1 ^ in_imm;
            OP_W'(OP_ORI):   res_val = in_value1 | in_imm;
            OP_W'(OP_ANDI):  res_val = in_value1 & in_imm;
            OP_W'(OP_SLLI):  res_val = in_value1 << sh_i;
            OP_W'(OP_SRLI):  res_val = in_value1 >> sh_i;
            OP_W'(OP_SRAI):  res_val = DATA_W'($signed(in_value1) >>> sh_i);
            default: ;
        endcase
        if (res_br) begin
            res_val = {{(DATA_W-1){1'b0}}, taken};
            res_npc = in_pc + in_imm;
        end
    end

    // ---------------- pipeline slots ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            br_q  <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                tag_q[i] <= '0;
                val_q[i] <= '0;
                npc_q[i] <= '0;
            end
        end else if (rdy) begin
            if (in_flush) begin
                // Flush wins over a stall; data is left as-is because
                // the outputs are masked whenever the last slot is invalid.
                vld_q <= '0;
            end else if (advance) begin
                vld_q[0] <= accept;
                br_q[0]  <= res_br;
                tag_q[0] <= in_rob_tag;
                val_q[0] <= res_val;
                npc_q[0] <= res_npc;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    br_q[i]  <= br_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                    val_q[i] <= val_q[i-1];
                    npc_q[i] <= npc_q[i-1];
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign out_rob_tag   = out_valid ? tag_q[LAST] : '0;
    assign out_value     = out_valid ? val_q[LAST] : '0;
    assign out_newpc     = out_valid ? npc_q[LAST] : '0;
    assign out_is_branch = out_valid & br_q[LAST];

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            occupancy = occupancy + 3'(vld_q[i]);
        end
    end

endmodule

// File: tb/tb_exec_unit_pipe.sv
module tb_exec_unit_pipe;
    import exec_unit_pipe_pkg::*;

    localparam int unsigned STAGES = 2;

    logic        clk = 1'b0;
    logic        rst, rdy, in_valid, in_ready, in_flush;
    logic [5:0]  in_op;
    logic [31:0] in_value1, in_value2, in_imm, in_pc;
    logic [3:0]  in_rob_tag;
    logic        out_valid, out_ready, out_is_branch;
    logic [3:0]  out_rob_tag;
    logic [31:0] out_value, out_newpc;
    logic [2:0]  occupancy;

    exec_unit_pipe #(
        .DATA_W(32), .TAG_W(4), .OP_W(6), .STAGES(STAGES)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_value1(in_value1), .in_value2(in_value2), .in_imm(in_imm),
        .in_pc(in_pc), .in_rob_tag(in_rob_tag), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob_tag(out_rob_tag),
        .out_value(out_value), .out_newpc(out_newpc),
        .out_is_branch(out_is_branch), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic [31:0] npc;
        logic        br;
        int          age;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] flag(input bit b);
        return b ? 32'd1 : 32'd0;
    endfunction

    // Reference semantics straight from the ISA description.
    function automatic ent_t model_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] imm, input logic [31:0] pc,
                                      input logic [3:0] tag);
        ent_t e;
        logic [4:0] sb, si;
        sb = b[4:0];
        si = imm[4:0];
        e.tag = tag; e.val = 32'd0; e.npc = 32'd0; e.br = 1'b0; e.age = 1;
        case (op)
            OP_LUI:   e.val = imm;
            OP_AUIPC: e.val = pc + imm;
            OP_JAL:   e.val = pc + 32'd4;
            OP_JALR:  begin e.val = pc + 32'd4; e.npc = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ:   begin e.br = 1; e.val = flag(a == b); end
            OP_BNE:   begin e.br = 1; e.val = flag(a != b); end
            OP_BLT:   begin e.br = 1; e.val = flag($signed(a) < $signed(b)); end
            OP_BGE:   begin e.br = 1; e.val = flag(!($signed(a) < $signed(b))); end
            OP_BLTU:  begin e.br = 1; e.val = flag(a < b); end
            OP_BGEU:  begin e.br = 1; e.val = flag(!(a < b)); end
            OP_ADD:   e.val = a + b;
            OP_SUB:   e.val = a - b;
            OP_SLL:   e.val = a << sb;
            OP_SRL:   e.val = a >> sb;
            OP_SRA:   e.val = a[31] ? ~((~a) >> sb) : (a >> sb);
            OP_SLT:   e.val = flag($signed(a) < $signed(b));
            OP_SLTU:  e.val = flag(a < b);
            OP_XOR:   e.val = a ^ b;
            OP_OR:    e.val = a | b;
            OP_AND:   e.val = a & b;
            OP_ADDI:  e.val = a + imm;
            OP_SLTI:  e.val = flag($signed(a) < $signed(imm));
            OP_SLTIU: e.val = flag(a < imm);
            OP_XORI:  e.val = a ^ imm;
            OP_ORI:   e.val = a | imm;
            OP_ANDI:  e.val = a & imm;
            OP_SLLI:  e.val = a << si;
            OP_SRLI:  e.val = a >> si;
            OP_SRAI:  e.val = a[31] ? ~((~a) >> si) : (a >> si);
            default:  ;
        endcase
        if (e.br) e.npc = pc + imm;
        return e;
    endfunction

    // Single compare process: checks outputs against the queue model,
    // then advances the model with the inputs that the next edge samples.
    always @(negedge clk) begin
        bit exp_ov, exp_ir;
        ent_t e;
        if (rst) begin
            mq.delete();
        end else if (checking) begin
            exp_ov = (mq.size() != 0) && (mq[0].age == STAGES);
            exp_ir = rdy && (out_ready || !exp_ov) && !in_flush;
            chk("out_valid", 32'(out_valid), flag(exp_ov));
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), flag(exp_ir));
            if (exp_ov) begin
                chk("out_tag", 32'(out_rob_tag), 32'(mq[0].tag));
                chk("out_value", out_value, mq[0].val);
                chk("out_newpc", out_newpc, mq[0].npc);
                chk("out_is_branch", 32'(out_is_branch), 32'(mq[0].br));
            end else begin
                chk("idle_data", out_value | out_newpc | 32'(out_rob_tag) | 32'(out_is_branch), 32'd0);
            end
            if (rdy) begin
                if (in_flush) begin
                    mq.delete();
                end else if (out_ready || !exp_ov) begin
                    if (exp_ov) void'(mq.pop_front());
                    foreach (mq[i]) mq[i].age++;
                    if (in_valid && in_op != 6'(OP_NOP)) begin
                        e = model_op(int'(in_op), in_value1, in_value2, in_imm, in_pc, in_rob_tag);
                        mq.push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        in_valid = 1'b1; in_op = 6'(op);
        in_value1 = a; in_value2 = b; in_imm = imm; in_pc = pc; in_rob_tag = tag;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    int op_tab[31];
    ent_t pe;

    initial begin
        for (int i = 0; i < 30; i++) op_tab[i] = i;
        op_tab[30] = 63;

        rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
        in_op = '0; in_value1 = '0; in_value2 = '0; in_imm = '0; in_pc = '0; in_rob_tag = '0;

        // Pin the model with hand-computed results.
        pe = model_op(OP_SUB, 32'd3, 32'd5, 32'd0, 32'd0, 4'd0);
        chk("pin_sub", pe.val, 32'hFFFF_FFFE);
        pe = model_op(OP_SRA, 32'h8000_0000, 32'd33, 32'd0, 32'd0, 4'd0);
        chk("pin_sra", pe.val, 32'hC000_0000);
        pe = model_op(OP_SRAI, 32'hF000_00F0, 32'd0, 32'd4, 32'd0, 4'd0);
        chk("pin_srai", pe.val, 32'hFF00_000F);
        pe = model_op(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 4'd0);
        chk("pin_blt_npc", pe.npc, 32'h0000_00F8);
        pe = model_op(OP_JALR, 32'h203, 32'd0, 32'd0, 32'h40, 4'd0);
        chk("pin_jalr_npc", pe.npc, 32'h202);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_value", out_value, 32'd0);
        checking = 1'b1;
        step();

        // ADD latency
        drive(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3);
        step(); in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_tag", 32'(out_rob_tag), 32'd3);
        chk("add_value", out_value, 32'd12);
        chk("add_npc", out_newpc, 32'd0);
        chk("add_br", 32'(out_is_branch), 32'd0);
        step();

        // Back-to-back
        drive(OP_SUB, 32'd3, 32'd5, 32'd0, 32'd0, 4'd1); step();
        drive(OP_SRA, 32'h8000_0000, 32'd33, 32'd0, 32'd0, 4'd2); step();
        drive(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd3);
        @(negedge clk); chk("b2b_sub", out_value, 32'hFFFF_FFFE);
        step(); in_valid = 1'b0;
        @(negedge clk); chk("b2b_sra", out_value, 32'hC000_0000);
        step();
        @(negedge clk); chk("b2b_sltu", out_value, 32'd1);
        step();

        // Branches / JALR
        drive(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 4'd4); step();
        drive(OP_BGEU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 4'd5); step();
        drive(OP_JALR, 32'h203, 32'd0, 32'd0, 32'h40, 4'd6);
        @(negedge clk);
        chk("blt_val", out_value, 32'd1);
        chk("blt_npc", out_newpc, 32'hF8);
        chk("blt_br", 32'(out_is_branch), 32'd1);
        step(); in_valid = 1'b0;
        @(negedge clk); chk("bgeu_val", out_value, 32'd1);
        step();
        @(negedge clk);
        chk("jalr_val", out_value, 32'h44);
        chk("jalr_npc", out_newpc, 32'h202);
        chk("jalr_br", 32'(out_is_branch), 32'd0);
        step();

        // Back-pressure
        out_ready = 1'b0;
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd7); step();
        drive(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 4'd8); step();
        drive(OP_ADD, 32'd3, 32'd3, 32'd0, 32'd0, 4'd9);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_occ", 32'(occupancy), 32'd2);
        chk("stall_tag", 32'(out_rob_tag), 32'd7);
        step(); step();
        @(negedge clk);
        chk("stall_hold_tag", 32'(out_rob_tag), 32'd7);
        chk("stall_hold_val", out_value, 32'd2);
        chk("stall_hold_occ", 32'(occupancy), 32'd2);
        step(); out_ready = 1'b1;
        @(negedge clk); chk("drain0", 32'(out_rob_tag), 32'd7);
        step(); in_valid = 1'b0;
        @(negedge clk); chk("drain1", 32'(out_rob_tag), 32'd8); chk("drain1_val", out_value, 32'd4);
        step();
        @(negedge clk); chk("drain2", 32'(out_rob_tag), 32'd9); chk("drain2_val", out_value, 32'd6);
        step();
        @(negedge clk); chk("drain_empty", 32'(out_valid), 32'd0);
        step();

        // Flush
        drive(OP_ADD, 32'd1, 32'd0, 32'd0, 32'd0, 4'd10); step();
        drive(OP_ADD, 32'd2, 32'd0, 32'd0, 32'd0, 4'd11); step();
        drive(OP_ADD, 32'd3, 32'd0, 32'd0, 32'd0, 4'd12); in_flush = 1'b1;
        @(negedge clk);
        chk("flush_pre_occ", 32'(occupancy), 32'd2);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step(); in_flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        step();
        @(negedge clk); chk("flush_gone", 32'(out_valid), 32'd0);
        step();

        // Asynchronous reset mid-stream
        drive(OP_ADD, 32'd1, 32'd0, 32'd0, 32'd0, 4'd1); step();
        drive(OP_ADD, 32'd2, 32'd0, 32'd0, 32'd0, 4'd2); step();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        @(negedge clk);
        step(); rst = 1'b0;
        @(negedge clk); chk("arst_after_occ", 32'(occupancy), 32'd0);
        step();

        // Freeze with rdy=0 (flush ignored meanwhile)
        drive(OP_ADD, 32'd10, 32'd10, 32'd0, 32'd0, 4'd13); step();
        drive(OP_ADD, 32'd20, 32'd20, 32'd0, 32'd0, 4'd14); step();
        drive(OP_ADD, 32'd30, 32'd30, 32'd0, 32'd0, 4'd15);
        rdy = 1'b0; in_flush = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("frz_occ", 32'(occupancy), 32'd2);
            chk("frz_tag", 32'(out_rob_tag), 32'd13);
            chk("frz_val", out_value, 32'd20);
            chk("frz_in_ready", 32'(in_ready), 32'd0);
        end
        step(); rdy = 1'b1; in_flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("frz_resume0", 32'(out_rob_tag), 32'd13);
        step();
        @(negedge clk); chk("frz_resume1", 32'(out_rob_tag), 32'd14); chk("frz_resume1_val", out_value, 32'd40);
        step();
        @(negedge clk); chk("frz_empty", 32'(out_valid), 32'd0);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rdy        = ($urandom_range(0, 9) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            in_flush   = ($urandom_range(0, 49) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_op      = 6'(op_tab[$urandom_range(0, 30)]);
            in_value1  = rand_val();
            in_value2  = rand_val();
            in_imm     = rand_val();
            in_pc      = 32'($urandom) & 32'hFFFF_FFFC;
            in_rob_tag = 4'($urandom);
            if (n == 1502) rst = 1'b0;
            if (n == 1500) begin
                #2 rst = 1'b1;
                #1;
                chk("rnd_arst_valid", 32'(out_valid), 32'd0);
                chk("rnd_arst_occ", 32'(occupancy), 32'd0);
            end
            step();
        end
        in_valid = 1'b0; in_flush = 1'b0; rdy = 1'b1; out_ready = 1'b1;
        repeat (STAGES + 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
